// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit engine.
// The BREAK state is used only when UART_TX_BREAK_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Number of bits needed to hold the values 0..n-1; never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: a down-counter that reloads on restart or after reaching zero.
// tick is high during the last clk cycle of each bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Count down one bit period; restart realigns the period to the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit engine: start bit, DATA_W data bits LSB first, optional parity,
// one or two stop bits. Frames chain back-to-back via the valid/ready handshake.
// Optional line-break generation is enabled with the macro UART_TX_BREAK_EN.
module uart_tx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        par_mode,
    input  logic              stop2,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
`ifdef UART_TX_BREAK_EN
    input  logic              tx_break,
`endif
    output logic              done
);

    localparam int BW = cnt_w(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    uart_state_t       state;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              par_en;
    logic              stop2_l;
    logic [BW-1:0]     bit_cnt;
    logic              stop_cnt;
    logic              brk_rel;
    logic              brk;
    logic              tick;
    logic              restart;
    logic              accept;
    logic              last_bit;
    logic              last_stop;

`ifdef UART_TX_BREAK_EN
    assign brk = tx_break;
`else
    assign brk = 1'b0;
`endif

    assign accept    = tx_valid && tx_ready;
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign last_stop = (stop_cnt == stop2_l);
    assign done      = (state == STOP) && tick && last_stop;
    assign tx_ready  = ((state == IDLE) || done) && !brk;
    assign busy      = (state != IDLE);
    assign restart   = accept || (state == IDLE) || ((state == BREAK) && !brk_rel);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    // Frame datapath: latch payload and options on accept, shift once per data bit.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg   <= tx_data;
            par_bit <= (^tx_data) ^ (par_mode == PAR_ODD);
            par_en  <= (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
            stop2_l <= stop2;
        end else if ((state == DATA) && tick && !last_bit) begin
            shreg <= shreg >> 1;
        end
    end

    // Frame sequencer with registered serial output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            brk_rel  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (brk) begin
                        state <= BREAK;
                        tx    <= 1'b0;
                    end else if (accept) begin
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (last_bit) begin
                            stop_cnt <= 1'b0;
                            if (par_en) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (!last_stop) begin
                            stop_cnt <= 1'b1;
                        end else if (brk) begin
                            state <= BREAK;
                            tx    <= 1'b0;
                        end else if (accept) begin
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (!brk_rel) begin
                        if (!brk) begin
                            brk_rel <= 1'b1;
                            tx      <= 1'b1;
                        end
                    end else if (tick) begin
                        brk_rel <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Testbench for uart_tx_frame_ctrl (DATA_W=8 and DATA_W=5, CLKS_PER_BIT=4).
// Break tests are included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_frame_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] par_mode;
    logic       stop2;
    logic       tx_ready, tx, busy, done;
    logic       tx_break;

    logic       v5;
    logic [4:0] d5;
    logic [1:0] pm5;
    logic       s25;
    logic       ready5, tx5, busy5, done5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.DATA_W(8), .CLKS_PER_BIT(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .par_mode(par_mode),
        .stop2   (stop2),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy),
`ifdef UART_TX_BREAK_EN
        .tx_break(tx_break),
`endif
        .done    (done)
    );

    uart_tx_frame_ctrl #(.DATA_W(5), .CLKS_PER_BIT(N)) dut5 (
        .clk     (clk),
        .reset   (reset),
        .tx_valid(v5),
        .tx_data (d5),
        .par_mode(pm5),
        .stop2   (s25),
        .tx_ready(ready5),
        .tx      (tx5),
        .busy    (busy5),
`ifdef UART_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .done    (done5)
    );

    typedef struct {
        logic [7:0] d;
        logic [1:0] pm;
        logic       s2;
        int         len;
        bit         pchk;
        logic       par;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endfunction

    function automatic void chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    // Present a frame in the next cycle; the following rising edge accepts it.
    task automatic start_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2);
        @(negedge clk);
        chk("idle_ready", tx_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        tx_valid = 1'b1;
        tx_data  = d;
        par_mode = pm;
        stop2    = s2;
    endtask

    // Reference waveform built from the frame rules, compared cycle by cycle.
    task automatic expect_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                                input bit hold, input logic [7:0] nd, input logic [1:0] npm,
                                input logic ns2);
        bit bits[$];
        bit q[$];
        int L;
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
        if (pm == 2'b01) bits.push_back(^d);
        else if (pm == 2'b10) bits.push_back(~^d);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[b]) repeat (N) q.push_back(bits[b]);
        L = q.size();
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            chk("frame_tx", tx, q[i]);
            chk("frame_done", done, i == L - 1);
            chk("frame_ready", tx_ready, i == L - 1);
            chk("frame_busy", busy, 1'b1);
            if (i == 0) begin
                if (!hold) tx_valid = 1'b0;
                tx_data  = 8'($urandom);
                par_mode = 2'($urandom);
                stop2    = 1'($urandom);
            end
            if (hold && i == L - 1) begin
                tx_data  = nd;
                par_mode = npm;
                stop2    = ns2;
            end
        end
    endtask

    // Record a frame until done and check its shape against a table entry.
    task automatic measure_frame(input vec_t v);
        bit rec[0:127];
        bit rdy[0:127];
        int n;
        start_frame(v.d, v.pm, v.s2);
        n = 0;
        for (int c = 1; c < 120; c++) begin
            @(negedge clk);
            if (c == 1) tx_valid = 1'b0;
            rec[c] = tx;
            rdy[c] = tx_ready;
            n = c;
            if (done) break;
        end
        chk_int("tbl_len", n, v.len);
        if (n == v.len) begin
            chk("tbl_start_first", rec[1], 1'b0);
            chk("tbl_start_last", rec[N], 1'b0);
            chk("tbl_stop_first", rec[n - (v.s2 ? 2 * N : N) + 1], 1'b1);
            chk("tbl_ready_at_done", rdy[n], 1'b1);
            chk("tbl_ready_before", rdy[n - 1], 1'b0);
            if (v.pchk) chk("tbl_parity", rec[9 * N + 1], v.par);
        end
    endtask

    initial begin
        logic [7:0] d, nd;
        logic [1:0] pm, npm;
        logic       s2, ns2;
        bit         b5[8];

        reset = 1'b1; tx_valid = 1'b0; tx_data = '0; par_mode = '0; stop2 = 1'b0;
        tx_break = 1'b0; v5 = 1'b0; d5 = '0; pm5 = '0; s25 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;

        tbl[0] = '{8'hA5, 2'b00, 1'b0, 40, 1'b0, 1'b0};
        tbl[1] = '{8'h07, 2'b01, 1'b0, 44, 1'b1, 1'b1};
        tbl[2] = '{8'h07, 2'b10, 1'b0, 44, 1'b1, 1'b0};
        tbl[3] = '{8'hA5, 2'b00, 1'b1, 44, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 2'b01, 1'b1, 48, 1'b1, 1'b0};
        tbl[5] = '{8'hFF, 2'b10, 1'b0, 44, 1'b1, 1'b1};
        tbl[6] = '{8'h3C, 2'b11, 1'b0, 40, 1'b0, 1'b0};
        for (int t = 0; t < 7; t++) measure_frame(tbl[t]);

        // 0xA5 waveform, then a back-to-back pair with tx_valid held high
        start_frame(8'hA5, 2'b00, 1'b0);
        expect_frame(8'hA5, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
        start_frame(8'h96, 2'b01, 1'b1);
        expect_frame(8'h96, 2'b01, 1'b1, 1'b1, 8'h3B, 2'b10, 1'b0);
        expect_frame(8'h3B, 2'b10, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
        @(negedge clk);
        chk("b2b_idle_tx", tx, 1'b1);
        chk("b2b_idle_done", done, 1'b0);

        // Randomized frames, some chained back-to-back
        for (int r = 0; r < 16; r++) begin
            d = 8'($urandom); pm = 2'($urandom); s2 = 1'($urandom);
            start_frame(d, pm, s2);
            if ($urandom_range(0, 1) == 1) begin
                nd = 8'($urandom); npm = 2'($urandom); ns2 = 1'($urandom);
                expect_frame(d, pm, s2, 1'b1, nd, npm, ns2);
                expect_frame(nd, npm, ns2, 1'b0, 8'h00, 2'b00, 1'b0);
            end else begin
                expect_frame(d, pm, s2, 1'b0, 8'h00, 2'b00, 1'b0);
            end
            @(negedge clk);
            chk("rnd_idle_tx", tx, 1'b1);
            chk("rnd_idle_busy", busy, 1'b0);
        end

        // Reset in the middle of the data bits
        start_frame(8'h5A, 2'b01, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_ready", tx_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        reset = 1'b0;
        start_frame(8'hC3, 2'b01, 1'b1);
        expect_frame(8'hC3, 2'b01, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);

        // DATA_W=5 instance: 0x1F with odd parity
        @(negedge clk);
        chk("w5_ready", ready5, 1'b1);
        v5 = 1'b1; d5 = 5'h1F; pm5 = 2'b10; s25 = 1'b0;
        b5[0] = 1'b0;
        for (int k = 0; k < 5; k++) b5[k + 1] = d5[k];
        b5[6] = ~^d5;
        b5[7] = 1'b1;
        for (int i = 0; i < 8 * N; i++) begin
            @(negedge clk);
            if (i == 0) begin v5 = 1'b0; d5 = 5'h00; pm5 = 2'b00; end
            chk("w5_tx", tx5, b5[i / N]);
            chk("w5_done", done5, i == 8 * N - 1);
        end
        @(negedge clk);
        chk("w5_idle_busy", busy5, 1'b0);

`ifdef UART_TX_BREAK_EN
        // Break held for 10 cycles with tx_valid also high: break wins
        @(negedge clk);
        tx_break = 1'b1; tx_valid = 1'b1; tx_data = 8'h55;
        chk("brk_ready_low", tx_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("brk_tx_low", tx, 1'b0);
            chk("brk_busy", busy, 1'b1);
            chk("brk_ready", tx_ready, 1'b0);
        end
        tx_break = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("brk_rel_tx", tx, 1'b1);
            chk("brk_rel_ready", tx_ready, 1'b0);
        end
        tx_valid = 1'b0;
        @(negedge clk);
        chk("brk_idle_ready", tx_ready, 1'b1);
        chk("brk_idle_busy", busy, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
